// File: rtl/multi_alarm_controller_pkg.sv
// Shared types and constants for the multi-channel alarm controller (package clock_pkg).
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEG_W  = 7;
  localparam int SNZ_W  = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1111110;

  // One seconds counter serves both the ring timeout and the snooze interval.
  function automatic int cnt_width(input int snooze_min, input int ring_timeout);
    int span;
    span = (snooze_min * 60 > ring_timeout) ? snooze_min * 60 : ring_timeout;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/multi_alarm_controller_if.sv
// Bundle of time, alarm, button and display signals between the time cores and the alarm controller.
interface multi_alarm_controller_if
  import clock_pkg::*;
#(
  parameter int N_ALARMS = 4,
  parameter int N_DIGITS = 6
);
  // No valid/ready pairs here: tick_sec, pulsed_up and pulsed_down are one-cycle strobes
  // acted on in the cycle they are high; every output is a level refreshed each clock.
  logic                        tick_sec;
  logic [HOUR_W-1:0]           cur_hours;
  logic [MIN_W-1:0]            cur_minutes;
  logic [MIN_W-1:0]            cur_seconds;
  logic                        editing;
  logic                        mode_active;
  logic [HOUR_W*N_ALARMS-1:0]  alarm_hours;
  logic [MIN_W*N_ALARMS-1:0]   alarm_minutes;
  logic [N_ALARMS-1:0]         alarm_enable;
  logic                        pulsed_up;
  logic                        pulsed_down;
  logic                        blink_phase;
  logic [SEG_W*N_DIGITS-1:0]   disp_in;
  logic [SEG_W*N_DIGITS-1:0]   disp_out;
  logic                        disp_mode;
  logic [N_ALARMS-1:0]         ringing;
  logic                        alert_any;
  logic                        chime;
  logic [2*N_ALARMS-1:0]       dbg_state;
  logic [SNZ_W*N_ALARMS-1:0]   dbg_snooze_cnt;

  modport master (
    output tick_sec, cur_hours, cur_minutes, cur_seconds, editing, mode_active,
           alarm_hours, alarm_minutes, alarm_enable, pulsed_up, pulsed_down,
           blink_phase, disp_in,
    input  disp_out, disp_mode, ringing, alert_any, chime, dbg_state, dbg_snooze_cnt
  );

  modport slave (
    input  tick_sec, cur_hours, cur_minutes, cur_seconds, editing, mode_active,
           alarm_hours, alarm_minutes, alarm_enable, pulsed_up, pulsed_down,
           blink_phase, disp_in,
    output disp_out, disp_mode, ringing, alert_any, chime, dbg_state, dbg_snooze_cnt
  );

endinterface

// File: rtl/multi_alarm_controller_channel.sv
// alarm_channel: one alarm's IDLE/RINGING/SNOOZED FSM with its seconds timer and snooze counter.
module alarm_channel
  import clock_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_sec,
  input  logic             enable,
  input  logic             match,
  input  logic             btn_up,
  input  logic             btn_down,
  output alarm_state_t     state,
  output logic [SNZ_W-1:0] snooze_cnt
);

  localparam int CNT_W = cnt_width(SNOOZE_MIN, RING_TIMEOUT_S);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_MIN * 60 - 1);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [SNZ_W-1:0] SNZ_MAX     = SNZ_W'(MAX_SNOOZE);

  alarm_state_t     state_q, state_d;
  logic [CNT_W-1:0] sec_q, sec_d;
  logic [SNZ_W-1:0] snz_q, snz_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sec_q   <= '0;
      snz_q   <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      snz_q   <= snz_d;
    end
  end

  // btn_up arrives already masked by btn_down, so dismiss always wins.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    snz_d   = snz_q;
    if (!enable) begin
      state_d = IDLE;
      sec_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_d = RINGING;
            sec_d   = '0;
            snz_d   = '0;
          end
        end
        RINGING: begin
          if (btn_down) begin
            state_d = IDLE;
          end else if (btn_up || (tick_sec && sec_q == RING_LAST)) begin
            sec_d = '0;
            if (snz_q < SNZ_MAX) begin
              state_d = SNOOZED;
              snz_d   = snz_q + SNZ_W'(1);
            end else begin
              state_d = IDLE;
            end
          end else if (tick_sec) begin
            sec_d = sec_q + CNT_W'(1);
          end
        end
        SNOOZED: begin
          if (btn_down) begin
            state_d = IDLE;
          end else if (tick_sec) begin
            if (sec_q == SNOOZE_LAST) begin
              state_d = RINGING;
              sec_d   = '0;
            end else begin
              sec_d = sec_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          sec_d   = '0;
        end
      endcase
    end
  end

  assign state      = state_q;
  assign snooze_cnt = snz_q;

endmodule

// File: rtl/multi_alarm_controller.sv
// N-channel alarm controller with 12/24 h mode register and alert blink gating of the digit bus.
// Build option: define HOURLY_CHIME_EN to generate the hourly chime pulse; otherwise chime is 0.
module multi_alarm_controller
  import clock_pkg::*;
#(
  parameter int N_ALARMS       = 4,
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int RING_TIMEOUT_S = 60,
  parameter int N_DIGITS       = 6
) (
  input logic clk,
  input logic reset,
  multi_alarm_controller_if.slave bus
);

  alarm_state_t        ch_state [N_ALARMS];
  logic [N_ALARMS-1:0] in_ring;
  logic [N_ALARMS-1:0] match;
  logic                up_eff;
  logic                mode_toggle;

  logic [N_ALARMS-1:0]       ringing_q;
  logic                      alert_q;
  logic                      mode_q;
  logic [SEG_W*N_DIGITS-1:0] disp_q;

  assign up_eff = bus.pulsed_up & ~bus.pulsed_down;

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_ch
    assign match[g] = bus.tick_sec & bus.alarm_enable[g] & ~bus.editing
                    & (bus.alarm_hours[HOUR_W*g +: HOUR_W] == bus.cur_hours)
                    & (bus.alarm_minutes[MIN_W*g +: MIN_W] == bus.cur_minutes)
                    & (bus.cur_seconds == '0);

    alarm_channel #(
      .SNOOZE_MIN     (SNOOZE_MIN),
      .MAX_SNOOZE     (MAX_SNOOZE),
      .RING_TIMEOUT_S (RING_TIMEOUT_S)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick_sec   (bus.tick_sec),
      .enable     (bus.alarm_enable[g]),
      .match      (match[g]),
      .btn_up     (up_eff),
      .btn_down   (bus.pulsed_down),
      .state      (ch_state[g]),
      .snooze_cnt (bus.dbg_snooze_cnt[SNZ_W*g +: SNZ_W])
    );

    assign in_ring[g]               = (ch_state[g] == RINGING);
    assign bus.dbg_state[2*g +: 2]  = ch_state[g];
  end

  // A channel already ringing consumes pulsed_up as snooze even before alert_any catches up.
  assign mode_toggle = bus.pulsed_up & ~alert_q & ~(|in_ring) & bus.mode_active & ~bus.editing;

  always_ff @(posedge clk) begin
    if (reset) begin
      ringing_q <= '0;
      alert_q   <= 1'b0;
      mode_q    <= 1'b0;
      disp_q    <= '0;
    end else begin
      ringing_q <= in_ring;
      alert_q   <= |in_ring;
      if (mode_toggle) mode_q <= ~mode_q;
      disp_q    <= (alert_q & ~bus.blink_phase) ? {N_DIGITS{SEG_BLANK}} : bus.disp_in;
    end
  end

`ifdef HOURLY_CHIME_EN
  logic chime_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= bus.tick_sec & (bus.cur_minutes == '0) & (bus.cur_seconds == '0)
               & ~bus.editing & ~alert_q;
    end
  end

  assign bus.chime = chime_q;
`else
  assign bus.chime = 1'b0;
`endif

  assign bus.ringing   = ringing_q;
  assign bus.alert_any = alert_q;
  assign bus.disp_mode = mode_q;
  assign bus.disp_out  = disp_q;

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Directed bench for multi_alarm_controller: driver tasks push expectations, a negedge monitor checks them.
module tb_multi_alarm_controller;
  import clock_pkg::*;

  localparam int NA = 2;
  localparam int ND = 6;
  localparam int DW = 7 * ND;
  localparam int W  = 52;

  localparam logic [3:0] K_RING  = 4'd0;
  localparam logic [3:0] K_ALERT = 4'd1;
  localparam logic [3:0] K_MODE  = 4'd2;
  localparam logic [3:0] K_DISP  = 4'd3;
  localparam logic [3:0] K_CHIME = 4'd4;
  localparam logic [3:0] K_ST0   = 4'd5;
  localparam logic [3:0] K_ST1   = 4'd6;
  localparam logic [3:0] K_SNZ0  = 4'd7;

  localparam logic [47:0] S_IDLE = 48'd0;
  localparam logic [47:0] S_RING = 48'd1;
  localparam logic [47:0] S_SNZ  = 48'd2;

  localparam logic [DW-1:0] PAT = {7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B};

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multi_alarm_controller_if #(.N_ALARMS(NA), .N_DIGITS(ND)) bus ();

  multi_alarm_controller #(
    .N_ALARMS       (NA),
    .SNOOZE_MIN     (5),
    .MAX_SNOOZE     (3),
    .RING_TIMEOUT_S (60),
    .N_DIGITS       (ND)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [47:0]  mon_act;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic string kname(input logic [3:0] k);
    case (k)
      K_RING:  return "ringing";
      K_ALERT: return "alert_any";
      K_MODE:  return "disp_mode";
      K_DISP:  return "disp_out";
      K_CHIME: return "chime";
      K_ST0:   return "ch0_state";
      K_ST1:   return "ch1_state";
      K_SNZ0:  return "ch0_snooze_cnt";
      default: return "unknown";
    endcase
  endfunction

  function logic [47:0] actual(input logic [3:0] k);
    case (k)
      K_RING:  return 48'(bus.ringing);
      K_ALERT: return 48'(bus.alert_any);
      K_MODE:  return 48'(bus.disp_mode);
      K_DISP:  return 48'(bus.disp_out);
      K_CHIME: return 48'(bus.chime);
      K_ST0:   return 48'(bus.dbg_state[1:0]);
      K_ST1:   return 48'(bus.dbg_state[3:2]);
      K_SNZ0:  return 48'(bus.dbg_snooze_cnt[3:0]);
      default: return 48'hDEAD;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = actual(mon_e[51:48]);
      n_cmp++;
      if (mon_act !== mon_e[47:0]) begin
        n_bad++;
        $display("FAIL %s: got %0h, expected %0h at %0t", kname(mon_e[51:48]), mon_act,
                 mon_e[47:0], $time);
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input logic [3:0] k, input logic [47:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic tick_at(input int h, input int m, input int s);
    bus.cur_hours   = 5'(h);
    bus.cur_minutes = 6'(m);
    bus.cur_seconds = 6'(s);
    bus.tick_sec    = 1'b1;
    cyc();
    bus.tick_sec    = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus.cur_seconds = 6'd7;
    bus.tick_sec    = 1'b1;
    repeat (n) cyc();
    bus.tick_sec    = 1'b0;
  endtask

  task automatic pulse(input logic up, input logic down);
    bus.pulsed_up   = up;
    bus.pulsed_down = down;
    cyc();
    bus.pulsed_up   = 1'b0;
    bus.pulsed_down = 1'b0;
  endtask

  initial begin
    bus.tick_sec      = 1'b0;
    bus.cur_hours     = '0;
    bus.cur_minutes   = '0;
    bus.cur_seconds   = '0;
    bus.editing       = 1'b0;
    bus.mode_active   = 1'b1;
    bus.alarm_hours   = {5'd12, 5'd7};
    bus.alarm_minutes = {6'd0, 6'd30};
    bus.alarm_enable  = 2'b01;
    bus.pulsed_up     = 1'b0;
    bus.pulsed_down   = 1'b0;
    bus.blink_phase   = 1'b0;
    bus.disp_in       = PAT;

    // reset state
    reset = 1'b1;
    repeat (2) cyc();
    expect_v(K_RING, 48'd0);
    expect_v(K_ALERT, 48'd0);
    expect_v(K_MODE, 48'd0);
    expect_v(K_DISP, 48'd0);
    expect_v(K_CHIME, 48'd0);
    expect_v(K_ST0, S_IDLE);
    reset = 1'b0;
    repeat (2) cyc();

    // ch0 fires at 07:30:00; outputs follow one cycle later, blank while blink low
    tick_at(7, 29, 59);
    expect_v(K_ST0, S_IDLE);
    tick_at(7, 30, 0);
    expect_v(K_ST0, S_RING);
    expect_v(K_RING, 48'd0);
    cyc();
    expect_v(K_RING, 48'd1);
    expect_v(K_ALERT, 48'd1);
    expect_v(K_DISP, 48'(PAT));
    cyc();
    expect_v(K_DISP, 48'd0);
    bus.blink_phase = 1'b1;
    cyc();
    expect_v(K_DISP, 48'(PAT));
    bus.blink_phase = 1'b0;

    // snooze cycle up to the limit
    pulse(1'b1, 1'b0);
    expect_v(K_ST0, S_SNZ);
    expect_v(K_SNZ0, 48'd1);
    expect_v(K_MODE, 48'd0);
    cyc();
    expect_v(K_RING, 48'd0);
    for (int k = 2; k <= 3; k++) begin
      ticks(299);
      expect_v(K_ST0, S_SNZ);
      ticks(1);
      expect_v(K_ST0, S_RING);
      cyc();
      expect_v(K_RING, 48'd1);
      pulse(1'b1, 1'b0);
      expect_v(K_ST0, S_SNZ);
      expect_v(K_SNZ0, 48'(k));
    end
    ticks(300);
    expect_v(K_ST0, S_RING);
    cyc();
    pulse(1'b1, 1'b0);
    expect_v(K_ST0, S_IDLE);
    expect_v(K_SNZ0, 48'd3);
    expect_v(K_MODE, 48'd0);
    cyc();
    expect_v(K_ALERT, 48'd0);
    expect_v(K_RING, 48'd0);

    // unattended ring times out into a snooze, then dismiss
    tick_at(7, 30, 0);
    expect_v(K_ST0, S_RING);
    expect_v(K_SNZ0, 48'd0);
    ticks(59);
    expect_v(K_ST0, S_RING);
    ticks(1);
    expect_v(K_ST0, S_SNZ);
    expect_v(K_SNZ0, 48'd1);
    pulse(1'b0, 1'b1);
    expect_v(K_ST0, S_IDLE);
    cyc();
    expect_v(K_ALERT, 48'd0);
    expect_v(K_RING, 48'd0);

    // two channels at 12:00; single dismiss clears both; up+down together dismisses
    bus.alarm_hours   = {5'd12, 5'd12};
    bus.alarm_minutes = {6'd0, 6'd0};
    bus.alarm_enable  = 2'b11;
    tick_at(12, 0, 0);
    cyc();
    expect_v(K_RING, 48'd3);
    pulse(1'b0, 1'b1);
    cyc();
    expect_v(K_RING, 48'd0);
    tick_at(12, 0, 0);
    cyc();
    expect_v(K_RING, 48'd3);
    pulse(1'b1, 1'b1);
    expect_v(K_ST0, S_IDLE);
    expect_v(K_ST1, S_IDLE);
    cyc();
    expect_v(K_RING, 48'd0);
    expect_v(K_MODE, 48'd0);

    // mode toggle rules and match suppression while editing
    pulse(1'b1, 1'b0);
    expect_v(K_MODE, 48'd1);
    bus.editing = 1'b1;
    pulse(1'b1, 1'b0);
    expect_v(K_MODE, 48'd1);
    tick_at(12, 0, 0);
    cyc();
    expect_v(K_RING, 48'd0);
    expect_v(K_ST0, S_IDLE);
    bus.editing = 1'b0;
    bus.mode_active = 1'b0;
    pulse(1'b1, 1'b0);
    expect_v(K_MODE, 48'd1);
    bus.mode_active = 1'b1;

    // dropping an enable forces that channel idle
    tick_at(12, 0, 0);
    bus.alarm_enable = 2'b10;
    cyc();
    expect_v(K_ST0, S_IDLE);
    expect_v(K_ST1, S_RING);
    cyc();
    expect_v(K_RING, 48'd2);
    bus.alarm_enable = 2'b11;
    pulse(1'b0, 1'b1);
    cyc();

    // reset in the middle of a snooze
    tick_at(12, 0, 0);
    cyc();
    pulse(1'b1, 1'b0);
    expect_v(K_ST0, S_SNZ);
    cyc();
    reset = 1'b1;
    cyc();
    expect_v(K_ST0, S_IDLE);
    expect_v(K_ST1, S_IDLE);
    expect_v(K_SNZ0, 48'd0);
    expect_v(K_RING, 48'd0);
    expect_v(K_ALERT, 48'd0);
    expect_v(K_MODE, 48'd0);
    expect_v(K_DISP, 48'd0);
    reset = 1'b0;
    cyc();
    ticks(5);
    expect_v(K_ST0, S_IDLE);
    expect_v(K_RING, 48'd0);

    // hourly chime
    tick_at(13, 0, 0);
`ifdef HOURLY_CHIME_EN
    expect_v(K_CHIME, 48'd1);
`else
    expect_v(K_CHIME, 48'd0);
`endif
    cyc();
    expect_v(K_CHIME, 48'd0);
    tick_at(13, 0, 1);
    expect_v(K_CHIME, 48'd0);

    cyc();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_alarm_controller.md
Name: multi_alarm_controller

Overview:
Parametrised successor to the single-alarm display wrapper. Supports N independent alarm channels, each with its own ring/snooze/dismiss state machine, snooze limits and ring timeout. Also owns the 12/24 display-mode register and the blink/blank gating of the seven-segment digit bus. Sits between the timekeeping cores (current 24 h time, digit bus) and the top-level display driver.

Parameters:
N_ALARMS, 4, number of alarm channels (1..8)
SNOOZE_MIN, 5, snooze length in minutes (1..30)
MAX_SNOOZE, 3, snoozes allowed per ring event before snooze acts as dismiss
RING_TIMEOUT_S, 60, seconds of unattended ringing before an automatic snooze
N_DIGITS, 6, seven-segment digits on the bus

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_sec  in  1  one-cycle pulse per second; cur_* already hold the new time on this cycle
cur_hours  in  5  current hour, 24 h (0..23)
cur_minutes  in  6  current minute
cur_seconds  in  6  current second
editing  in  1  a time core is in set mode; suppresses matches and mode toggle
mode_active  in  1  top-level mode is clock view
alarm_hours  in  5*N_ALARMS  per-channel alarm hour, channel i at [5i+4:5i]
alarm_minutes  in  6*N_ALARMS  per-channel alarm minute
alarm_enable  in  N_ALARMS  per-channel arm
pulsed_up  in  1  one-cycle button pulse: snooze when ringing, otherwise mode toggle
pulsed_down  in  1  one-cycle button pulse: dismiss
blink_phase  in  1  quarter-second square wave
disp_in  in  7*N_DIGITS  digit bus from the time cores
disp_out  out  7*N_DIGITS  gated digit bus
disp_mode  out  1  0 = 24 h, 1 = 12 h
ringing  out  N_ALARMS  one bit per channel in RINGING
alert_any  out  1  OR of ringing
chime  out  1  hourly chime pulse (see Optional Feature)

Behaviour:
- Reset state: all channels IDLE, counters 0, disp_mode=0, ringing=0, alert_any=0, disp_out=0, chime=0.
- Channel FSM states:
  - IDLE -> RINGING on match. Match = tick_sec & alarm_enable[i] & !editing & hours/minutes equal & cur_seconds==0. snooze_cnt cleared.
  - RINGING -> IDLE on pulsed_down.
  - RINGING -> SNOOZED on pulsed_up when snooze_cnt<MAX_SNOOZE; snooze_cnt++. When snooze_cnt==MAX_SNOOZE, pulsed_up -> IDLE.
  - RINGING -> timeout after RING_TIMEOUT_S ticks: handled as pulsed_up (SNOOZED or IDLE).
  - SNOOZED -> RINGING after SNOOZE_MIN*60 ticks. ring_sec restarts at 0.
  - SNOOZED -> IDLE on pulsed_down.
- Counter width: ceil(log2(SNOOZE_MIN*60+1)). Counters advance only on tick_sec.
- Buttons act on every channel currently in the relevant state in the same cycle.
- Simultaneous events:
  - match beats button for that channel; a channel entering RINGING ignores same-cycle buttons;
  - pulsed_down beats pulsed_up;
  - alarm_enable[i] low forces IDLE next cycle from any state.
- Mode toggle: pulsed_up & !alert_any & mode_active & !editing flips disp_mode. A pulsed_up consumed as snooze never toggles.
- Display, registered with 1-cycle latency: disp_out = (alert_any & !blink_phase) ? all zeros : disp_in.
- ringing and alert_any are registered from FSM state, so they update the cycle after the transition.
- Reset mid-ring or mid-snooze: immediate return to reset state; no pending ring survives.

Optional Feature:
- HOURLY_CHIME_EN defined: chime is a one-cycle pulse, registered, on tick_sec with cur_minutes==0 & cur_seconds==0 & !editing. Suppressed while alert_any.
- Not defined: chime tied 0 and no logic generated.

Decomposition:
- Package clock_pkg holds:
  - alarm_state_t enum {IDLE, RINGING, SNOOZED};
  - SEG_BLANK = 7'b0000000;
  - SEG_ZERO = 7'b1111110;
  - HOUR_W=5, MIN_W=6, SEG_W=7.
- Sub-module alarm_channel: one FSM, its ring_sec/snooze timers and snooze_cnt. Instantiated N_ALARMS times via generate. The top holds button arbitration, mode register, display gating and chime.

Test Plan:
- N_ALARMS=2, ch0 07:30 enabled; drive time to 07:29:59 then tick -> ringing=01, alert_any=1 one cycle later; disp_out zero while blink_phase=0, else equals disp_in.
- While ch0 ringing, pulsed_up -> SNOOZED, disp_mode unchanged. After 300 ticks (SNOOZE_MIN=5) -> RINGING again. Fourth snooze attempt (MAX_SNOOZE=3) -> IDLE.
- Ringing with no buttons for 60 ticks -> auto-snooze, snooze_cnt=1. Then pulsed_down -> IDLE, alert_any=0.
- ch0 and ch1 both at 12:00 -> ringing=11. Single pulsed_down -> ringing=00. pulsed_up and pulsed_down same cycle -> dismiss.
- No alarm: pulsed_up with mode_active=1, editing=0 -> disp_mode 0->1. With editing=1 -> unchanged. Match time crossed while editing=1 -> no ring.
- Reset asserted mid-snooze -> all outputs at reset values next cycle. HOURLY_CHIME_EN: 13:00:00 tick -> chime one-cycle pulse; without the macro, chime stays 0.
